// File: rtl/pid_cfg_pkg.sv
// Shared constants and types for the PID coefficient scheduler.
// Holds the register map, FSM state encoding, FP32 reset values and
// the reset image of a 12-word coefficient bank.
package pid_cfg_pkg;

    localparam int unsigned NUM_CFG_REGS = 12;
    localparam int unsigned CFG_DW       = 32;
    localparam int unsigned CFG_AW       = 4;

    // Register map
    localparam logic [CFG_AW-1:0] CFG_A0         = 4'd0;
    localparam logic [CFG_AW-1:0] CFG_C1         = 4'd1;
    localparam logic [CFG_AW-1:0] CFG_C2         = 4'd2;
    localparam logic [CFG_AW-1:0] CFG_C3         = 4'd3;
    localparam logic [CFG_AW-1:0] CFG_C4         = 4'd4;
    localparam logic [CFG_AW-1:0] CFG_C5         = 4'd5;
    localparam logic [CFG_AW-1:0] CFG_C6         = 4'd6;
    localparam logic [CFG_AW-1:0] CFG_C7         = 4'd7;
    localparam logic [CFG_AW-1:0] CFG_C8         = 4'd8;
    localparam logic [CFG_AW-1:0] CFG_YSAT       = 4'd9;
    localparam logic [CFG_AW-1:0] CFG_RECIP_YSAT = 4'd10;
    localparam logic [CFG_AW-1:0] CFG_W_TARGET   = 4'd11;

    // FP32 reset constants
    localparam logic [CFG_DW-1:0] FP32_ZERO           = 32'h0000_0000;
    localparam logic [CFG_DW-1:0] FP32_YSAT_RST       = 32'h4140_0000; // 12.0f
    localparam logic [CFG_DW-1:0] FP32_RECIP_YSAT_RST = 32'h3DAA_AAAB; // 1/12

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } cfg_state_e;

    typedef logic [NUM_CFG_REGS-1:0][CFG_DW-1:0] cfg_bank_t;

    function automatic logic cfg_addr_valid(input logic [CFG_AW-1:0] addr);
        return addr <= CFG_W_TARGET;
    endfunction

    // Reset image: everything zero except the two saturation words.
    function automatic cfg_bank_t cfg_bank_reset(input logic [CFG_DW-1:0] ysat,
                                                 input logic [CFG_DW-1:0] recip_ysat);
        cfg_bank_t bank;
        for (int i = 0; i < int'(NUM_CFG_REGS); i++) begin
            bank[i] = FP32_ZERO;
        end
        bank[CFG_YSAT]       = ysat;
        bank[CFG_RECIP_YSAT] = recip_ysat;
        return bank;
    endfunction

endpackage

// File: rtl/cfg_shadow_bank.sv
// Shadow coefficient bank: 12 x 32-bit write-addressed registers.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   i_wr_en           write strobe (already qualified by the FSM state)
//   i_addr, i_wdata   register index and FP32 data
//   o_bank            full shadow contents, read in parallel by the commit
//   o_addr_invalid_c  combinational flag: i_addr is outside the register map
module cfg_shadow_bank
    import pid_cfg_pkg::*;
#(
    parameter logic [31:0] YSAT_RST       = FP32_YSAT_RST,
    parameter logic [31:0] RECIP_YSAT_RST = FP32_RECIP_YSAT_RST
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [3:0]       i_addr,
    input  logic [31:0]      i_wdata,
    output cfg_bank_t        o_bank,
    output logic             o_addr_invalid_c
);

    cfg_bank_t r_bank;

    assign o_addr_invalid_c = !cfg_addr_valid(i_addr);
    assign o_bank           = r_bank;

    // Decoded per-word write; invalid addresses match no word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank <= cfg_bank_reset(YSAT_RST, RECIP_YSAT_RST);
        end else if (i_wr_en) begin
            for (int i = 0; i < int'(NUM_CFG_REGS); i++) begin
                if (i_addr == CFG_AW'(i)) begin
                    r_bank[i] <= i_wdata;
                end
            end
        end
    end

endmodule

// File: rtl/pid_coef_scheduler.sv
// Configuration sequencer for the motor control loop. The host fills a shadow
// bank; a commit copies all 12 words into the live bank in one edge, but only
// on a cycle where the PID datapath is idle and no encoder sample launches.
// Ports:
//   aclk, rst_n                     clock, async active-low reset
//   cfg_wr_en/cfg_addr/cfg_wdata    shadow write port (addr 12..15 invalid)
//   cfg_commit                      request to publish shadow -> live
//   pid_busy, pid_data_valid        PID activity; either blocks the copy
//   a0_out .. w_target_out          registered live bank
//   commit_pending                  commit waiting for an idle window
//   commit_done / commit_err        one-cycle pulses: copied / timed out
//   cfg_wr_err                      one-cycle pulse on a rejected write
//   bank_gen                        successful commit count, wraps
module pid_coef_scheduler
    import pid_cfg_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC    = 100_000,
    parameter logic [31:0] YSAT_RST       = FP32_YSAT_RST,
    parameter logic [31:0] RECIP_YSAT_RST = FP32_RECIP_YSAT_RST
) (
    input  logic        aclk,
    input  logic        rst_n,
    input  logic        cfg_wr_en,
    input  logic [3:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    input  logic        cfg_commit,
    input  logic        pid_busy,
    input  logic        pid_data_valid,
    output logic [31:0] a0_out,
    output logic [31:0] c1_out,
    output logic [31:0] c2_out,
    output logic [31:0] c3_out,
    output logic [31:0] c4_out,
    output logic [31:0] c5_out,
    output logic [31:0] c6_out,
    output logic [31:0] c7_out,
    output logic [31:0] c8_out,
    output logic [31:0] ysat_out,
    output logic [31:0] recip_ysat_out,
    output logic [31:0] w_target_out,
    output logic        commit_pending,
    output logic        commit_done,
    output logic        commit_err,
    output logic        cfg_wr_err,
    output logic [7:0]  bank_gen
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    cfg_state_e       r_state;
    cfg_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_nxt;
    logic             w_copy;
    logic             w_timeout;

    cfg_bank_t        w_shadow;
    cfg_bank_t        r_live;
    logic             w_addr_invalid_c;
    logic             w_wr_accept;
    logic             w_wr_reject;
    logic             w_eligible;

    logic             r_commit_pending;
    logic             r_commit_done;
    logic             r_commit_err;
    logic             r_cfg_wr_err;
    logic [7:0]       r_bank_gen;

    // Writes land only in IDLE; a write alongside cfg_commit still counts.
    assign w_wr_accept = cfg_wr_en && (r_state == IDLE);
    assign w_wr_reject = cfg_wr_en && ((r_state == PENDING) || w_addr_invalid_c);
    assign w_eligible  = !pid_busy && !pid_data_valid;

    cfg_shadow_bank #(
        .YSAT_RST       (YSAT_RST),
        .RECIP_YSAT_RST (RECIP_YSAT_RST)
    ) u_shadow (
        .clk              (aclk),
        .rst_n            (rst_n),
        .i_wr_en          (w_wr_accept),
        .i_addr           (cfg_addr),
        .i_wdata          (cfg_wdata),
        .o_bank           (w_shadow),
        .o_addr_invalid_c (w_addr_invalid_c)
    );

    // State and wait counter
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // Next state; an eligible cycle wins over a timeout on the same cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_copy         = 1'b0;
        w_timeout      = 1'b0;
        case (r_state)
            IDLE: begin
                if (cfg_commit) begin
                    w_state_nxt    = PENDING;
                    w_wait_cnt_nxt = '0;
                end
            end
            PENDING: begin
                if (w_eligible) begin
                    w_copy      = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_wait_cnt == CNT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Live bank, generation counter and status pulses
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            r_live           <= cfg_bank_reset(YSAT_RST, RECIP_YSAT_RST);
            r_bank_gen       <= 8'd0;
            r_commit_pending <= 1'b0;
            r_commit_done    <= 1'b0;
            r_commit_err     <= 1'b0;
            r_cfg_wr_err     <= 1'b0;
        end else begin
            if (w_copy) begin
                r_live     <= w_shadow;
                r_bank_gen <= r_bank_gen + 8'd1;
            end
            r_commit_pending <= (w_state_nxt == PENDING);
            r_commit_done    <= w_copy;
            r_commit_err     <= w_timeout;
            r_cfg_wr_err     <= w_wr_reject;
        end
    end

    assign a0_out         = r_live[CFG_A0];
    assign c1_out         = r_live[CFG_C1];
    assign c2_out         = r_live[CFG_C2];
    assign c3_out         = r_live[CFG_C3];
    assign c4_out         = r_live[CFG_C4];
    assign c5_out         = r_live[CFG_C5];
    assign c6_out         = r_live[CFG_C6];
    assign c7_out         = r_live[CFG_C7];
    assign c8_out         = r_live[CFG_C8];
    assign ysat_out       = r_live[CFG_YSAT];
    assign recip_ysat_out = r_live[CFG_RECIP_YSAT];
    assign w_target_out   = r_live[CFG_W_TARGET];

    assign commit_pending = r_commit_pending;
    assign commit_done    = r_commit_done;
    assign commit_err     = r_commit_err;
    assign cfg_wr_err     = r_cfg_wr_err;
    assign bank_gen       = r_bank_gen;

endmodule

// File: tb/tb_pid_coef_scheduler.sv
// Directed bench for pid_coef_scheduler with a short commit timeout.
module tb_pid_coef_scheduler;

    logic        aclk = 1'b0;
    logic        rst_n;
    logic        cfg_wr_en;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        cfg_commit;
    logic        pid_busy;
    logic        pid_data_valid;
    logic [31:0] a0_out, c1_out, c2_out, c3_out, c4_out, c5_out, c6_out;
    logic [31:0] c7_out, c8_out, ysat_out, recip_ysat_out, w_target_out;
    logic        commit_pending, commit_done, commit_err, cfg_wr_err;
    logic [7:0]  bank_gen;

    logic [31:0] w_live [12];
    logic [31:0] exp_live [12];
    logic [31:0] exp_shadow [12];
    logic [7:0]  exp_gen;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 aclk = ~aclk;

    pid_coef_scheduler #(
        .TIMEOUT_CYC    (16),
        .YSAT_RST       (32'h41400000),
        .RECIP_YSAT_RST (32'h3DAAAAAB)
    ) dut (
        .aclk           (aclk),
        .rst_n          (rst_n),
        .cfg_wr_en      (cfg_wr_en),
        .cfg_addr       (cfg_addr),
        .cfg_wdata      (cfg_wdata),
        .cfg_commit     (cfg_commit),
        .pid_busy       (pid_busy),
        .pid_data_valid (pid_data_valid),
        .a0_out         (a0_out),
        .c1_out         (c1_out),
        .c2_out         (c2_out),
        .c3_out         (c3_out),
        .c4_out         (c4_out),
        .c5_out         (c5_out),
        .c6_out         (c6_out),
        .c7_out         (c7_out),
        .c8_out         (c8_out),
        .ysat_out       (ysat_out),
        .recip_ysat_out (recip_ysat_out),
        .w_target_out   (w_target_out),
        .commit_pending (commit_pending),
        .commit_done    (commit_done),
        .commit_err     (commit_err),
        .cfg_wr_err     (cfg_wr_err),
        .bank_gen       (bank_gen)
    );

    assign w_live[0]  = a0_out;
    assign w_live[1]  = c1_out;
    assign w_live[2]  = c2_out;
    assign w_live[3]  = c3_out;
    assign w_live[4]  = c4_out;
    assign w_live[5]  = c5_out;
    assign w_live[6]  = c6_out;
    assign w_live[7]  = c7_out;
    assign w_live[8]  = c8_out;
    assign w_live[9]  = ysat_out;
    assign w_live[10] = recip_ysat_out;
    assign w_live[11] = w_target_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 12; i++) begin
            exp_live[i]   = 32'h0;
            exp_shadow[i] = 32'h0;
        end
        exp_live[9]    = 32'h41400000;
        exp_live[10]   = 32'h3DAAAAAB;
        exp_shadow[9]  = 32'h41400000;
        exp_shadow[10] = 32'h3DAAAAAB;
        exp_gen        = 8'd0;
    endtask

    task automatic check_live(input string tag);
        for (int i = 0; i < 12; i++) chk($sformatf("%s_live%0d", tag, i), w_live[i], exp_live[i]);
    endtask

    task automatic check_status(input string tag, input logic pend, input logic done,
                                input logic err);
        chk({tag, "_pending"}, 32'(commit_pending), 32'(pend));
        chk({tag, "_done"},    32'(commit_done),    32'(done));
        chk({tag, "_err"},     32'(commit_err),     32'(err));
        chk({tag, "_gen"},     32'(bank_gen),       32'(exp_gen));
    endtask

    // Single write from IDLE; checks the reject flag one cycle later.
    task automatic wr(input logic [3:0] addr, input logic [31:0] data);
        logic bad;
        bad       = (addr >= 4'd12);
        cfg_wr_en = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        tick();
        cfg_wr_en = 1'b0;
        if (!bad) exp_shadow[addr] = data;
        chk($sformatf("wr_err_a%0d", addr), 32'(cfg_wr_err), 32'(bad));
    endtask

    task automatic publish();
        for (int i = 0; i < 12; i++) exp_live[i] = exp_shadow[i];
        exp_gen = exp_gen + 8'd1;
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_wr_en = 1'b0; cfg_addr = 4'd0; cfg_wdata = 32'h0;
        cfg_commit = 1'b0; pid_busy = 1'b0; pid_data_valid = 1'b0;
        model_reset();
        repeat (3) @(posedge aclk);
        #1;
        check_live("rst");
        check_status("rst", 1'b0, 1'b0, 1'b0);
        chk("rst_wr_err", 32'(cfg_wr_err), 32'h0);
        rst_n = 1'b1;
        tick();

        // Basic commit, best-case latency of two cycles
        wr(4'd0, 32'h3F800000);
        chk("pre_commit_a0", a0_out, 32'h0);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        check_status("basic_t1", 1'b1, 1'b0, 1'b0);
        chk("basic_t1_a0", a0_out, 32'h0);
        tick();
        publish();
        chk("basic_t2_a0", a0_out, 32'h3F800000);
        check_status("basic_t2", 1'b0, 1'b1, 1'b0);
        tick();
        check_status("basic_t3", 1'b0, 1'b0, 1'b0);

        // Commit held off by pid_busy, with a rejected write during the wait
        wr(4'd3, 32'h40490FDB);
        pid_busy   = 1'b1;
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        for (int i = 0; i < 11; i++) begin
            chk("busy_pending", 32'(commit_pending), 32'h1);
            chk("busy_done", 32'(commit_done), 32'h0);
            chk("busy_c3", c3_out, exp_live[3]);
            cfg_wr_en = (i == 2);
            cfg_addr  = 4'd4;
            cfg_wdata = 32'hDEADBEEF;
            tick();
            if (i == 2) chk("busy_wr_err", 32'(cfg_wr_err), 32'h1);
        end
        cfg_wr_en = 1'b0;
        pid_busy  = 1'b0;
        chk("busy_last_c3", c3_out, exp_live[3]);
        tick();
        publish();
        check_live("busy_done");
        check_status("busy_done", 1'b0, 1'b1, 1'b0);
        chk("busy_c4_untouched", c4_out, 32'h0);
        tick();

        // Write together with commit; pid_data_valid defers the copy by one
        cfg_wr_en  = 1'b1;
        cfg_addr   = 4'd5;
        cfg_wdata  = 32'hBF000000;
        cfg_commit = 1'b1;
        tick();
        exp_shadow[5] = 32'hBF000000;
        cfg_wr_en  = 1'b0;
        cfg_commit = 1'b0;
        pid_data_valid = 1'b1;
        chk("dv_t1_wr_err", 32'(cfg_wr_err), 32'h0);
        tick();
        pid_data_valid = 1'b0;
        chk("dv_t2_c5", c5_out, 32'h0);
        check_status("dv_t2", 1'b1, 1'b0, 1'b0);
        tick();
        publish();
        chk("dv_t3_c5", c5_out, 32'hBF000000);
        check_status("dv_t3", 1'b0, 1'b1, 1'b0);
        tick();

        // Timeout with pid_busy stuck high; a second commit while waiting is dropped
        wr(4'd8, 32'h12345678);
        pid_busy   = 1'b1;
        cfg_commit = 1'b1;
        tick();
        for (int j = 0; j < 16; j++) begin
            cfg_commit = (j == 5);
            chk("to_pending", 32'(commit_pending), 32'h1);
            chk("to_err", 32'(commit_err), 32'h0);
            tick();
        end
        cfg_commit = 1'b0;
        check_status("to_abort", 1'b0, 1'b0, 1'b1);
        check_live("to_abort");
        pid_busy = 1'b0;
        tick();
        check_status("to_after", 1'b0, 1'b0, 1'b0);
        wr(4'd13, 32'hCAFEF00D);
        wr(4'd12, 32'h0BADF00D);
        chk("bad_addr_live", c8_out, 32'h0);

        // Generation counter wrap over 253 more commits (3 -> 0)
        for (int k = 0; k < 253; k++) begin
            cfg_commit = 1'b1;
            tick();
            cfg_commit = 1'b0;
            tick();
            publish();
            chk("wrap_done", 32'(commit_done), 32'h1);
            if (k == 251) chk("wrap_gen_255", 32'(bank_gen), 32'hFF);
        end
        chk("wrap_gen_0", 32'(bank_gen), 32'h0);
        chk("wrap_c8", c8_out, 32'h12345678);
        tick();

        // Asynchronous reset in the middle of a pending commit
        wr(4'd11, 32'h42C80000);
        pid_busy   = 1'b1;
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        chk("mid_pending", 32'(commit_pending), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_live("mid_rst");
        check_status("mid_rst", 1'b0, 1'b0, 1'b0);
        pid_busy = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check_status("post_rst", 1'b0, 1'b0, 1'b0);
        chk("post_rst_wtarget", w_target_out, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
